// File: rtl/decoder_req_scheduler_if.sv
// Request, decoder and response bundle between client logic, the shared
// decoder instance and decoder_req_scheduler.
interface decoder_req_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int OUT_W   = 8
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [7*NUM_REQ-1:0] req_code;
    logic [NUM_REQ-1:0]   req_ready;
    logic [6:0]           dec_in;
    logic [OUT_W-1:0]     dec_out;
    logic                 rsp_valid;
    logic [ID_W-1:0]      rsp_id;
    logic [OUT_W-1:0]     rsp_data;
    logic                 rsp_ready;
    logic                 busy;

    modport slave (
        input  req_valid, req_code, dec_out, rsp_ready,
        output req_ready, dec_in, rsp_valid, rsp_id, rsp_data, busy
    );

    modport master (
        output req_valid, req_code, dec_out, rsp_ready,
        input  req_ready, dec_in, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/decoder_req_scheduler.sv
// Round-robin scheduler sharing one combinational decoder between NUM_REQ
// requesters: grant, drive code, wait DEC_LAT settle cycles, capture, respond.
module decoder_req_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int OUT_W   = 8,
    parameter int DEC_LAT = 1
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    decoder_req_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic [ID_W-1:0]    ptr_r;
    logic [ID_W-1:0]    ptr_nx_s;
    logic [ID_W-1:0]    win_s;
    logic               found_s;
    logic [6:0]         win_code_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [3:0]         cnt_r;
    logic [6:0]         dec_in_r;
    logic [ID_W-1:0]    rsp_id_r;
    logic [OUT_W-1:0]   rsp_data_r;
    logic               rsp_valid_r;
    logic               busy_r;

    // First asserted requester scanning upward from ptr, wrapping at NUM_REQ.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    ptr);
        logic               found;
        logic [ID_W-1:0]    win;
        logic [NUM_REQ-1:0] sh;
        int                 idx;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            sh  = valid >> idx;
            if (!found && sh[0]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end else begin
                found = found;
            end
        end
        return {found, win};
    endfunction

    function automatic logic [6:0] code_of(input logic [7*NUM_REQ-1:0] codes,
                                           input logic [ID_W-1:0]      id);
        logic [7*NUM_REQ-1:0] sh;
        sh = codes >> (7 * int'(id));
        return sh[6:0];
    endfunction

    // Arbiter: winner, its code, the advanced pointer and the one-hot accept.
    always_comb begin
        {found_s, win_s} = rr_pick(bus.req_valid, ptr_r);
        win_code_s       = code_of(bus.req_code, win_s);
        if (win_s == ID_W'(NUM_REQ - 1)) begin
            ptr_nx_s = '0;
        end else begin
            ptr_nx_s = win_s + ID_W'(1);
        end
        grant_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if ((state_r == IDLE) && found_s && (win_s == ID_W'(i))) begin
                grant_s[i] = 1'b1;
            end else begin
                grant_s[i] = 1'b0;
            end
        end
    end

    // Next-state decode.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_nx_s = WAIT;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_nx_s = RESP;
                end else begin
                    state_nx_s = WAIT;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = RESP;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State register; busy and rsp_valid are registered from the next state.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            busy_r      <= (state_nx_s != IDLE);
            rsp_valid_r <= (state_nx_s == RESP);
        end
    end

    // Datapath: grant latch, settle countdown and decoder capture.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ptr_r      <= '0;
            cnt_r      <= 4'd0;
            dec_in_r   <= 7'h00;
            rsp_id_r   <= '0;
            rsp_data_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        dec_in_r <= win_code_s;
                        rsp_id_r <= win_s;
                        cnt_r    <= 4'(DEC_LAT);
                        ptr_r    <= ptr_nx_s;
                    end
                end
                WAIT: begin
                    if (cnt_r == 4'd0) begin
                        rsp_data_r <= bus.dec_out;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                RESP: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= 4'd0;
                end
            endcase
        end
    end

    assign bus.req_ready = grant_s;
    assign bus.dec_in    = dec_in_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_id    = rsp_id_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_decoder_req_scheduler.sv
// Bench for decoder_req_scheduler: three instances (DEC_LAT 0, 1, 15) share
// stimulus; a transaction-age model checks every cycle, directed literals pin it.
module tb_decoder_req_scheduler;

    localparam int NR = 4;
    localparam int IW = 2;
    localparam int OW = 8;
    localparam int NI = 3;

    function automatic int lat_of(input int g);
        case (g)
            0:       return 0;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [7*NR-1:0] req_code;
    logic            rsp_ready;
    logic [OW-1:0]   dec_out_a   [NI];
    logic [NR-1:0]   req_ready_a [NI];
    logic [6:0]      dec_in_a    [NI];
    logic            rsp_valid_a [NI];
    logic [IW-1:0]   rsp_id_a    [NI];
    logic [OW-1:0]   rsp_data_a  [NI];
    logic            busy_a      [NI];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : gi
        decoder_req_scheduler_if #(.NUM_REQ(NR), .ID_W(IW), .OUT_W(OW)) bus ();
        decoder_req_scheduler #(.NUM_REQ(NR), .ID_W(IW), .OUT_W(OW), .DEC_LAT(lat_of(g))) dut (
            .wb_clk_i (clk),
            .wb_rst_i (rst),
            .bus      (bus.slave)
        );
        assign bus.req_valid  = req_valid;
        assign bus.req_code   = req_code;
        assign bus.rsp_ready  = rsp_ready;
        assign bus.dec_out    = dec_out_a[g];
        assign req_ready_a[g] = bus.req_ready;
        assign dec_in_a[g]    = bus.dec_in;
        assign rsp_valid_a[g] = bus.rsp_valid;
        assign rsp_id_a[g]    = bus.rsp_id;
        assign rsp_data_a[g]  = bus.rsp_data;
        assign busy_a[g]      = bus.busy;
    end

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d got=%h want=%h t=%0t", name, inst, act, exp, $time);
        end
    endtask

    // Reference model: a transaction is described only by its age since grant.
    bit          known = 1'b0;
    bit          m_active [NI];
    int          m_age    [NI];
    int          m_ptr    [NI];
    logic [6:0]  m_dec_in [NI];
    logic [IW-1:0] m_id   [NI];
    logic [OW-1:0] m_data [NI];

    always @(negedge clk) begin : model_cmp
        int              lat;
        int              w;
        int              idx;
        logic [NR-1:0]   exp_rdy;
        logic [NR-1:0]   vsh;
        logic [7*NR-1:0] csh;
        for (int i = 0; i < NI; i++) begin
            lat = lat_of(i);
            w   = -1;
            if (!m_active[i]) begin
                for (int k = 0; k < NR; k++) begin
                    idx = (m_ptr[i] + k) % NR;
                    vsh = req_valid >> idx;
                    if (w < 0 && vsh[0]) w = idx;
                end
            end
            exp_rdy = (w >= 0) ? (NR'(1) << w) : '0;
            if (known) begin
                chk("busy",      i, busy_a[i],      m_active[i]);
                chk("rsp_valid", i, rsp_valid_a[i], m_active[i] && (m_age[i] >= lat + 2));
                chk("req_ready", i, req_ready_a[i], exp_rdy);
                chk("dec_in",    i, dec_in_a[i],    m_dec_in[i]);
                chk("rsp_id",    i, rsp_id_a[i],    m_id[i]);
                chk("rsp_data",  i, rsp_data_a[i],  m_data[i]);
            end
            if (rst) begin
                m_active[i] = 1'b0;
                m_age[i]    = 0;
                m_ptr[i]    = 0;
                m_dec_in[i] = 7'h00;
                m_id[i]     = '0;
                m_data[i]   = '0;
            end else if (!m_active[i]) begin
                if (w >= 0) begin
                    csh         = req_code >> (7 * w);
                    m_active[i] = 1'b1;
                    m_age[i]    = 1;
                    m_dec_in[i] = csh[6:0];
                    m_id[i]     = IW'(w);
                    m_ptr[i]    = (w + 1) % NR;
                end
            end else if (m_age[i] <= lat) begin
                m_age[i]++;
            end else if (m_age[i] == lat + 1) begin
                m_data[i] = dec_out_a[i];
                m_age[i]++;
            end else if (rsp_ready) begin
                m_active[i] = 1'b0;
            end
        end
        if (rst) known = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_code(input int r, input logic [6:0] c);
        req_code[7*r +: 7] = c;
    endtask

    task automatic wait_all_idle(input string name);
        int n;
        n = 0;
        while ((busy_a[0] || busy_a[1] || busy_a[2]) && n < 80) begin
            tick();
            #1;
            n++;
        end
        chk(name, -1, {busy_a[0], busy_a[1], busy_a[2]}, 3'b000);
    endtask

    initial begin
        int gcount;
        int gcyc [5];
        int gid  [5];
        int n;
        int n3;
        rst       = 1'b1;
        req_valid = '0;
        req_code  = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NI; i++) dec_out_a[i] = '0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("rst_busy",      1, busy_a[1],      1'b0);
        chk("rst_dec_in",    1, dec_in_a[1],    7'h00);
        chk("rst_rsp_valid", 1, rsp_valid_a[1], 1'b0);
        chk("rst_rsp_id",    1, rsp_id_a[1],    2'd0);
        chk("rst_rsp_data",  1, rsp_data_a[1],  8'h00);
        chk("rst_req_ready", 1, req_ready_a[1], 4'b0000);

        // Requester 1 alone; instance 2 sees a toggling decoder until capture.
        for (int i = 0; i < NI; i++) dec_out_a[i] = 8'h5A;
        req_valid = 4'b0010;
        set_code(1, 7'b1000100);
        #1;
        chk("t1_grant", 1, req_ready_a[1], 4'b0010);
        for (int c = 1; c <= 18; c++) begin
            tick();
            req_valid    = '0;
            dec_out_a[2] = (c == 16) ? 8'hC3 : 8'(c);
            #1;
            case (c)
                1: begin
                    chk("t1_dec_in", 1, dec_in_a[1],    7'b1000100);
                    chk("t1_v0_lo",  0, rsp_valid_a[0], 1'b0);
                    chk("t1_v1_lo",  1, rsp_valid_a[1], 1'b0);
                end
                2: begin
                    chk("t1_v0_hi",   0, rsp_valid_a[0], 1'b1);
                    chk("t1_d0",      0, rsp_data_a[0],  8'h5A);
                    chk("t1_v1_lo2",  1, rsp_valid_a[1], 1'b0);
                end
                3: begin
                    chk("t1_v1_hi", 1, rsp_valid_a[1], 1'b1);
                    chk("t1_id1",   1, rsp_id_a[1],    2'd1);
                    chk("t1_d1",    1, rsp_data_a[1],  8'h5A);
                end
                16: chk("t1_v2_lo", 2, rsp_valid_a[2], 1'b0);
                17: begin
                    chk("t1_v2_hi", 2, rsp_valid_a[2], 1'b1);
                    chk("t1_d2",    2, rsp_data_a[2],  8'hC3);
                end
                default: ;
            endcase
        end

        // Reset pulse, then all four requesters held valid.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rp_busy",   1, busy_a[1],   1'b0);
        chk("rp_dec_in", 1, dec_in_a[1], 7'h00);
        for (int r = 0; r < NR; r++) set_code(r, 7'(7'h10 + r));
        req_valid = 4'hF;
        #1;
        gcount = 0;
        for (int c = 0; c < 20; c++) begin
            if (req_ready_a[1] != '0 && gcount < 5) begin
                gcyc[gcount] = c;
                for (int k = 0; k < NR; k++) if (req_ready_a[1][k]) gid[gcount] = k;
                gcount++;
            end
            tick();
            #1;
        end
        chk("rr_count", 1, gcount, 5);
        for (int k = 0; k < 5; k++) begin
            chk("rr_id",  1, gid[k],  k % NR);
            chk("rr_cyc", 1, gcyc[k], 4 * k);
        end

        // Backpressure: instance 1 holds requester 1's response.
        rsp_ready = 1'b0;
        n = 0;
        while (!rsp_valid_a[1] && n < 40) begin
            tick();
            #1;
            n++;
        end
        chk("bp_reach", 1, rsp_valid_a[1], 1'b1);
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < NI; i++) dec_out_a[i] = 8'($urandom);
            tick();
            #1;
            chk("bp_valid", 1, rsp_valid_a[1], 1'b1);
            chk("bp_id",    1, rsp_id_a[1],    2'd1);
            chk("bp_data",  1, rsp_data_a[1],  8'h5A);
            chk("bp_rdy",   1, req_ready_a[1], 4'b0000);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_hs_rdy", 1, req_ready_a[1], 4'b0000);
        tick();
        #1;
        chk("bp_next", 1, req_ready_a[1] != '0, 1'b1);

        // Reset while waiting discards the transaction and the pointer.
        req_valid = '0;
        wait_all_idle("idle_a");
        req_valid = 4'b0010;
        #1;
        chk("rw_grant", 1, req_ready_a[1], 4'b0010);
        tick();
        req_valid = '0;
        rst = 1'b1;
        #1;
        chk("rw_busy_pre", 1, busy_a[1], 1'b1);
        tick();
        rst = 1'b0;
        req_valid = 4'b0101;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("rw_busy",  i, busy_a[i],      1'b0);
            chk("rw_valid", i, rsp_valid_a[i], 1'b0);
            chk("rw_dec",   i, dec_in_a[i],    7'h00);
        end
        chk("rw_ptr0", 1, req_ready_a[1], 4'b0001);
        tick();
        req_valid = '0;
        #1;
        wait_all_idle("idle_b");

        // Code changes after grant are ignored; requester 3 withdraws in time.
        req_valid = 4'b0100;
        set_code(2, 7'h2B);
        #1;
        chk("cc_grant", 1, req_ready_a[1], 4'b0100);
        tick();
        set_code(2, 7'h55);
        req_valid = 4'b1000;
        #1;
        chk("cc_dec1", 1, dec_in_a[1], 7'h2B);
        tick();
        req_valid = '0;
        #1;
        chk("cc_dec2", 1, dec_in_a[1], 7'h2B);
        n3 = 0;
        for (int c = 0; c < 25; c++) begin
            if (rsp_valid_a[1] && rsp_id_a[1] == 2'd3) n3++;
            tick();
            #1;
        end
        chk("drop_id3", 1, n3, 0);
        chk("drop_idle", 1, busy_a[1], 1'b0);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            tick();
            req_valid = NR'($urandom);
            req_code  = (7*NR)'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < NI; i++) dec_out_a[i] = 8'($urandom);
        end
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decoder_req_scheduler.md
Name: decoder_req_scheduler

Overview:
- Shares the single combinational decoder datapath (7-bit `io_in` code in, `OUT_W`-bit decoded word out) between `NUM_REQ` requesters.
- Requests are served one at a time with round-robin fairness.
- The block drives the decoder input, waits a programmable settle time and captures the decoder output.
- It returns the result with the requester ID over a valid/ready response channel.
- It sits between the user-project client logic and the decoder instance.

Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ID_W`, 2: width of the requester index, equal to clog2(`NUM_REQ`).
- `OUT_W`, 8: width of the decoder output word.
- `DEC_LAT`, 1: settle cycles between driving `dec_in` and capturing `dec_out`, 0..15.

Ports:
- `wb_clk_i`  in  1  system clock.
- `wb_rst_i`  in  1  synchronous active-high reset.
- `req_valid`  in  `NUM_REQ`  per-requester request strobe; held until accepted.
- `req_code`  in  7*`NUM_REQ`  packed request codes; requester i uses bits [7i+6:7i].
- `req_ready`  out  `NUM_REQ`  one-hot accept; the request is taken when `req_valid[i]` and `req_ready[i]` are both high.
- `dec_in`  out  7  code driven to the decoder `io_in`.
- `dec_out`  in  `OUT_W`  decoder output.
- `rsp_valid`  out  1  response available.
- `rsp_id`  out  `ID_W`  index of the requester being answered.
- `rsp_data`  out  `OUT_W`  captured decoder output.
- `rsp_ready`  in  1  consumer accepts the response.
- `busy`  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values (`wb_rst_i` sampled high at a clock edge):
  - state = IDLE; `req_ready`=0; `dec_in`=7'h00; `rsp_valid`=0; `rsp_id`=0; `rsp_data`=0; `busy`=0.
  - Settle counter = 0; round-robin pointer = 0, so requester 0 has highest priority.
- States: IDLE, WAIT, RESP.
- IDLE:
  - `req_ready` is combinational.
  - If any `req_valid` is high, grant the first asserted requester scanning upward (modulo `NUM_REQ`) from the pointer.
  - Assert `req_ready` only for that requester in that cycle.
  - On the clock edge: latch its code into `dec_in` and its index into `rsp_id`, load the counter with `DEC_LAT`, set the pointer to winner+1 (wrapping `NUM_REQ`-1 to 0), and go to WAIT.
  - If no request is valid, stay in IDLE; `req_ready`=0 and `dec_in` holds its last value.
- WAIT:
  - `req_ready`=0.
  - If the counter is 0: capture `dec_out` into `rsp_data` and go to RESP.
  - Otherwise decrement the counter.
  - `dec_in` is stable throughout WAIT.
- RESP:
  - `rsp_valid`=1, with `rsp_id` and `rsp_data` stable until the handshake.
  - On `rsp_valid` & `rsp_ready`: go to IDLE, with `rsp_valid` low the next cycle.
  - No grant is issued in the handshake cycle.
- Latency: handshake at cycle t → `dec_in` valid from t+1 → capture at the end of cycle t+1+`DEC_LAT` → `rsp_valid` high from t+2+`DEC_LAT`.
- Throughput: at most one request per `DEC_LAT`+3 cycles, assuming `rsp_ready` is tied high.
- Fairness: a continuously asserting requester cannot be granted twice while another requester is waiting.
  - With all `NUM_REQ` requesters asserted, the grant order from reset is 0,1,2,...,`NUM_REQ`-1,0.
- A `req_valid` that deasserts before its grant is dropped with no side effect.
- `req_code` is sampled only in the grant cycle; later changes are ignored.
- `dec_out` is sampled only in the capture cycle.
- Response backpressure: `rsp_ready` low holds RESP indefinitely; all `req_ready` stay 0 meanwhile.
- Reset mid-operation (any state): return to the reset values in the next cycle.
  - An in-flight request is discarded with no response.
  - The pointer returns to 0.
- `busy` = (state != IDLE), registered alongside the state.

Test Plan:
- Reset, then requester 1 alone with code 7'b1000100, `DEC_LAT`=1, decoder model output 8'h5A → `req_ready`=4'b0010 for one cycle; `dec_in`=7'b1000100 from t+1; `rsp_valid` at t+3 with `rsp_id`=1, `rsp_data`=8'h5A.
- All 4 requesters held valid, `rsp_ready`=1 → grant order 0,1,2,3,0; successive grants 4 cycles apart with `DEC_LAT`=1.
- `rsp_ready` low for 10 cycles in RESP → `rsp_valid`, `rsp_id` and `rsp_data` stable; `req_ready`=0 throughout; the next grant comes only after the handshake.
- `DEC_LAT`=0 → capture occurs one cycle after `dec_in` updates; `rsp_valid` at t+2. `DEC_LAT`=15 → `rsp_valid` at t+17. `dec_out` toggled during WAIT → only the capture-cycle value appears in `rsp_data`.
- Assert `wb_rst_i` for one cycle during WAIT → next cycle state is IDLE, `busy`=0, `dec_in`=0, no response emitted; requester 0 wins the next contention.
- Requester 2 changes `req_code` the cycle after its grant → `dec_in` keeps the granted code; requester 3 drops `req_valid` before being granted → no grant and no response for ID 3.
